mfe_host_ctrl: RTL and testbench
================================

# mfe_host_ctrl

Host-side controller for the median filter engine (MFE): launches the MFE with the `ready`/`busy` handshake, grants it the result-memory bus while it runs, then reads the finished result image back out of that memory. The read-back leaves as a backpressured pixel stream with a running checksum. It sits between the system sequencer, the MFE, and the single-port result RAM.

## Interface
- ADDR_W, 14, result memory address width
- DATA_W, 8, pixel width
- NPIX, 16384, pixels read back per run (128x128)
- CSUM_W, 24, checksum width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to run one image
- mfe_busy  in  1  MFE busy flag
- mfe_ready  out  1  MFE launch request
- mfe_addr  in  ADDR_W  MFE result-memory address
- mfe_wen  in  1  MFE write enable (1 write, 0 read)
- mfe_data_wr  in  DATA_W  MFE write data
- mfe_data_rd  out  DATA_W  read data returned to MFE
- mem_addr  out  ADDR_W  result RAM address
- mem_wen  out  1  result RAM write enable
- mem_wdata  out  DATA_W  result RAM write data
- mem_rdata  in  DATA_W  result RAM read data, valid one cycle after address
- out_valid  out  1  stream pixel valid
- out_ready  in  1  stream consumer ready
- out_data  out  DATA_W  stream pixel
- out_last  out  1  marks pixel NPIX-1
- done  out  1  one-cycle pulse after last pixel accepted
- checksum  out  CSUM_W  sum of streamed pixels, mod 2^CSUM_W

## Operation
- States: IDLE, WAIT_IDLE, LAUNCH, RUN, READ, FINISH.
- IDLE: `start` -> WAIT_IDLE. `start` in any other state is ignored. `checksum` is cleared on entry to WAIT_IDLE.
- WAIT_IDLE: wait for `mfe_busy`=0. Then `mfe_ready`=1 and go to LAUNCH.
- LAUNCH: hold `mfe_ready`=1 until `mfe_busy`=1 is sampled. That same edge clears `mfe_ready` and enters RUN.
- RUN: the bus is passed through combinationally:
  - `mem_addr`=`mfe_addr`, `mem_wen`=`mfe_wen`, `mem_wdata`=`mfe_data_wr`, `mfe_data_rd`=`mem_rdata`.
  - When `mfe_busy`=0 is sampled, the read pointer is cleared and the state goes to READ.
- Outside RUN: `mem_wen`=0, `mem_addr`=read pointer, `mem_wdata`=0, `mfe_data_rd`=0.
- READ:
  - A read is issued (pointer advances) only when buffer occupancy plus in-flight reads is less than 2 and pointer < NPIX.
  - Each returned `mem_rdata` is pushed into a 2-entry output buffer.
  - The stream pops the buffer on `out_valid & out_ready`.
  - `out_last`=1 on pixel index NPIX-1.
  - `checksum` += `out_data` on each accepted pixel, unsigned, wraps mod 2^CSUM_W.
- Acceptance of the last pixel -> FINISH: `done`=1 for one cycle, then IDLE. `checksum` holds until the next `start`.
- The pointer is ADDR_W+1 bits wide, so NPIX=2^ADDR_W does not alias to 0.

## Timing
- Reset values: `mfe_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `done`=0, `checksum`=0, `mem_wen`=0, `mem_addr`=0; state IDLE; buffer empty.
- Reset mid-operation aborts immediately: buffer flushed, in-flight read discarded, no `done`.
- `start` -> `mfe_ready` high: 1 cycle minimum, when `mfe_busy` is already 0.
- RUN pass-through adds zero cycles.
- READ first pixel: `out_valid` rises 2 cycles after READ entry (1 cycle issue, 1 cycle RAM latency).
- Steady state with `out_ready`=1: one pixel per cycle, NPIX+2 cycles from READ entry to last acceptance.
- `out_valid` is never deasserted while `out_ready`=0. `out_data`/`out_last` are stable until accepted.
- `out_ready` toggling must never drop or duplicate a pixel. Buffer full stops issue; the in-flight read always has a free slot.

## Structure
- Package `mfe_pkg`: ADDR_W, DATA_W, NPIX, CSUM_W constants; state enum `mfe_host_state_t`.
- Sub-module `mfe_out_buf`: 2-entry FIFO with push/pop/full/empty/count, data+last payload. It carries the stream-side backpressure.
- Top level holds the FSM, read pointer, in-flight flag, bus mux and checksum.

## Test plan
- Nominal run: MFE model rises busy 3 cycles after `mfe_ready`, writes addr k with k[7:0] for 20 cycles, drops busy -> `mfe_ready` high exactly until busy seen; RAM holds the writes; pixels stream 0,1,2,... with `out_last` only on index 16383; `done` pulses once.
- Checksum: RAM preloaded all 0xFF -> `checksum`=0x3FC000 after `done`; all 0x01 -> 0x004000.
- Backpressure: `out_ready` random 30% duty -> stream identical to the `out_ready`=1 run, no gaps in data order, `out_valid` never drops while stalled.
- Launch wait: `mfe_busy` held 1 at `start` for 10 cycles -> `mfe_ready` stays 0 until busy falls, then asserts next cycle.
- Ignored start / reset: `start` pulsed during RUN has no effect; `reset` at pixel 500 -> all outputs at reset values next cycle, a new `start` completes a full 16384-pixel run.

Source files
------------

// File: rtl/mfe_pkg.sv
// Shared constants and state encoding for the MFE host controller.
package mfe_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int NPIX   = 16384;
    localparam int CSUM_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_LAUNCH,
        S_RUN,
        S_READ,
        S_FINISH
    } mfe_host_state_t;

endpackage

// File: rtl/mfe_out_buf.sv
// Two-entry output FIFO carrying pixel data plus end-of-image flag.
module mfe_out_buf
    import mfe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_q] <= push_data_i;
                last_q[wr_q] <= push_last_i;
                wr_q         <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Head entry stays put until popped, so the stream is stable under stall.
    assign data_o  = data_q[rd_q];
    assign last_o  = last_q[rd_q] & (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/mfe_host_ctrl.sv
// Launches the MFE, lends it the result RAM, then streams the image back.
module mfe_host_ctrl
    import mfe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mfe_busy,
    output logic              mfe_ready,
    input  logic [ADDR_W-1:0] mfe_addr,
    input  logic              mfe_wen,
    input  logic [DATA_W-1:0] mfe_data_wr,
    output logic [DATA_W-1:0] mfe_data_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic [CSUM_W-1:0] checksum
);

    localparam logic [ADDR_W:0] NPIX_P = (ADDR_W+1)'(NPIX);
    localparam logic [ADDR_W:0] LAST_P = (ADDR_W+1)'(NPIX - 1);

    mfe_host_state_t   state_q;
    logic [ADDR_W:0]   ptr_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              mfe_ready_q;
    logic              done_q;
    logic [CSUM_W-1:0] csum_q;
    logic [1:0]        buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic              accept;
    logic              issue;
    logic [2:0]        occ;

    mfe_out_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (mem_rdata),
        .push_last_i (inflight_last_q),
        .pop_i       (accept),
        .data_o      (out_data),
        .last_o      (out_last),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign out_valid = ~buf_empty;
    assign accept    = out_valid & out_ready;

    // A slot freed by this cycle's pop counts, which keeps one pixel per cycle.
    assign occ   = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, accept};
    assign issue = (state_q == S_READ) && (occ < 3'd2) &&
                   (ptr_q < NPIX_P) && !(buf_full && !accept);

    always_comb begin
        mem_addr    = ptr_q[ADDR_W-1:0];
        mem_wen     = 1'b0;
        mem_wdata   = '0;
        mfe_data_rd = '0;
        if (state_q == S_RUN) begin
            mem_addr    = mfe_addr;
            mem_wen     = mfe_wen;
            mem_wdata   = mfe_data_wr;
            mfe_data_rd = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            mfe_ready_q     <= 1'b0;
            done_q          <= 1'b0;
            csum_q          <= '0;
        end else begin
            inflight_q <= issue;
            done_q     <= 1'b0;
            if (issue) begin
                ptr_q           <= ptr_q + 1'b1;
                inflight_last_q <= (ptr_q == LAST_P);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        csum_q  <= '0;
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!mfe_busy) begin
                        mfe_ready_q <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (mfe_busy) begin
                        mfe_ready_q <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!mfe_busy) begin
                        ptr_q   <= '0;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (accept) begin
                        csum_q <= csum_q + CSUM_W'(out_data);
                        if (out_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign mfe_ready = mfe_ready_q;
    assign done      = done_q;
    assign checksum  = csum_q;

endmodule

// File: tb/tb_mfe_host_ctrl.sv
// Bench for mfe_host_ctrl: RAM and MFE models, bus table, stream scoreboard.
module tb_mfe_host_ctrl;
    import mfe_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mfe_busy;
    logic              mfe_ready;
    logic [ADDR_W-1:0] mfe_addr;
    logic              mfe_wen;
    logic [DATA_W-1:0] mfe_data_wr;
    logic [DATA_W-1:0] mfe_data_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;
    logic [CSUM_W-1:0] checksum;

    always #5 clk = ~clk;

    mfe_host_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mfe_busy    (mfe_busy),
        .mfe_ready   (mfe_ready),
        .mfe_addr    (mfe_addr),
        .mfe_wen     (mfe_wen),
        .mfe_data_wr (mfe_data_wr),
        .mfe_data_rd (mfe_data_rd),
        .mem_addr    (mem_addr),
        .mem_wen     (mem_wen),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .done        (done),
        .checksum    (checksum)
    );

    logic [DATA_W-1:0] ram [NPIX];
    logic              fill_en;
    logic              fill_mode;
    logic [7:0]        fill_val;

    initial begin
        forever begin
            @(posedge clk);
            if (fill_en) begin
                for (int k = 0; k < NPIX; k++)
                    ram[k] <= fill_mode ? fill_val : (k < 20 ? 8'hAA : 8'(k));
            end else if (mem_wen) begin
                ram[mem_addr] <= mem_wdata;
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } pix_t;

    pix_t sbq[$];
    int   pix_cnt = 0;

    initial begin
        logic       stall;
        logic [7:0] st_d;
        logic       st_l;
        pix_t       exp;
        stall = 1'b0;
        st_d  = '0;
        st_l  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (stall)
                    chk("stall_hold", {out_valid, out_data, out_last},
                        {1'b1, st_d, st_l});
                if (out_valid && out_ready) begin
                    chk("sb_avail", 64'(sbq.size() != 0), 64'd1);
                    if (sbq.size() != 0) begin
                        exp = sbq.pop_front();
                        chk($sformatf("pixel%0d", pix_cnt),
                            {out_data, out_last}, exp);
                    end
                    pix_cnt++;
                end
                stall = out_valid && !out_ready;
                st_d  = out_data;
                st_l  = out_last;
            end else begin
                stall = 1'b0;
            end
        end
    end

    typedef struct {
        logic [13:0] addr;
        logic        wen;
        logic [7:0]  wd;
        logic [13:0] e_addr;
        logic        e_wen;
        logic [7:0]  e_wd;
        logic        chk_rd;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t tv [26];

    function automatic logic [63:0] rst_vec();
        return 64'({mfe_ready, out_valid, out_last, out_data, done,
                    checksum, mem_wen, mem_addr});
    endfunction

    task automatic apply_row(input int r, input string nm);
        mfe_addr    = tv[r].addr;
        mfe_wen     = tv[r].wen;
        mfe_data_wr = tv[r].wd;
        #1;
        chk(nm, {mem_addr, mem_wen, mem_wdata},
            {tv[r].e_addr, tv[r].e_wen, tv[r].e_wd});
        if (tv[r].chk_rd)
            chk({nm, "_rd"}, mfe_data_rd, tv[r].e_rd);
        tick();
    endtask

    task automatic do_run(input int hold, input bit wr_tbl, input bit st_run,
                          input int rdy_pct, input int abort_at,
                          input logic [23:0] exp_cs, input bit fill,
                          input bit fmode, input logic [7:0] fval);
        int first;
        int done_at;
        int n_done;
        if (fill) begin
            fill_mode = fmode;
            fill_val  = fval;
            fill_en   = 1'b1;
            tick();
            fill_en = 1'b0;
        end
        for (int k = 0; k < NPIX; k++)
            sbq.push_back('{d: (fmode ? fval : 8'(k)), l: (k == NPIX - 1)});
        pix_cnt   = 0;
        out_ready = 1'b1;
        mfe_busy  = (hold > 0);
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("csum_clear", checksum, 0);
        chk("ready_wait", mfe_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("ready_held_off", mfe_ready, 0);
        end
        mfe_busy = 1'b0;
        tick();
        chk("ready_rise", mfe_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ready_hold", mfe_ready, 1);
        end
        mfe_busy = 1'b1;
        tick();
        chk("ready_fall", mfe_ready, 0);
        if (st_run) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (wr_tbl) begin
            for (int r = 0; r < 23; r++)
                apply_row(r, "run_bus");
        end else begin
            repeat (5) tick();
        end
        mfe_wen     = 1'b0;
        mfe_addr    = '0;
        mfe_data_wr = '0;
        mfe_busy    = 1'b0;
        tick();
        first   = -1;
        done_at = -1;
        n_done  = 0;
        for (int cyc = 1; cyc < 40000; cyc++) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            tick();
            if (out_valid && first < 0)
                first = cyc;
            if (done) begin
                n_done++;
                done_at = cyc;
            end
            if (abort_at > 0 && pix_cnt >= abort_at) begin
                reset = 1'b1;
                tick();
                chk("abort_reset_vals", rst_vec(), 0);
                reset = 1'b0;
                sbq.delete();
                tick();
                chk("abort_no_done", done, 0);
                out_ready = 1'b1;
                return;
            end
            if (done_at > 0 && cyc >= done_at + 3)
                break;
        end
        out_ready = 1'b1;
        chk("done_seen", 64'(done_at > 0), 1);
        chk("first_valid", first, 2);
        if (rdy_pct >= 100)
            chk("latency", done_at, NPIX + 2);
        chk("done_once", n_done, 1);
        chk("checksum", checksum, exp_cs);
        chk("sb_empty", sbq.size(), 0);
        chk("no_relaunch", mfe_ready, 0);
    endtask

    initial begin
        for (int k = 0; k < 20; k++)
            tv[k] = '{14'(k), 1'b1, 8'(k), 14'(k), 1'b1, 8'(k), 1'b0, 8'h00};
        tv[20] = '{14'd19, 1'b0, 8'hC3, 14'd19, 1'b0, 8'hC3, 1'b0, 8'h00};
        tv[21] = '{14'd3, 1'b0, 8'hC3, 14'd3, 1'b0, 8'hC3, 1'b1, 8'd19};
        tv[22] = '{14'd3, 1'b0, 8'h3C, 14'd3, 1'b0, 8'h3C, 1'b1, 8'd3};
        tv[23] = '{14'h1234, 1'b1, 8'h5A, 14'd0, 1'b0, 8'h00, 1'b1, 8'h00};
        tv[24] = '{14'h3FFF, 1'b1, 8'hFF, 14'd0, 1'b0, 8'h00, 1'b1, 8'h00};
        tv[25] = '{14'h0001, 1'b0, 8'h11, 14'd0, 1'b0, 8'h00, 1'b1, 8'h00};

        reset       = 1'b1;
        start       = 1'b0;
        mfe_busy    = 1'b0;
        mfe_addr    = '0;
        mfe_wen     = 1'b0;
        mfe_data_wr = '0;
        out_ready   = 1'b1;
        fill_en     = 1'b0;
        fill_mode   = 1'b0;
        fill_val    = '0;
        repeat (2) tick();
        chk("reset_vals", rst_vec(), 0);
        reset = 1'b0;
        tick();
        for (int r = 23; r < 26; r++)
            apply_row(r, "idle_bus");
        mfe_wen = 1'b0;

        do_run(10, 1'b1, 1'b0, 100, 0, 24'h1FE000, 1'b1, 1'b0, 8'h00);
        do_run(0, 1'b0, 1'b1, 70, 0, 24'h1FE000, 1'b0, 1'b0, 8'h00);
        do_run(0, 1'b0, 1'b0, 100, 500, 24'h000000, 1'b1, 1'b1, 8'hFF);
        do_run(0, 1'b0, 1'b0, 100, 0, 24'h3FC000, 1'b0, 1'b1, 8'hFF);
        do_run(0, 1'b0, 1'b0, 100, 0, 24'h004000, 1'b1, 1'b1, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
